// File: rtl/sram_ctrl_pkg.sv
// Shared types and default parameters for the word-cell array sequencing controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RESP
    } state_e;

    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_WR_CYCLES = 1;

endpackage

// File: rtl/word_decoder.sv
// Combinational address to one-hot word select; addresses past DEPTH select nothing and raise oor_o.
module word_decoder
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DEPTH-1:0]  sel_o,
    output logic              oor_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign sel_o[gi] = (addr_i == ADDR_W'(gi));
        end
    endgenerate

    // Widened compare stays meaningful even when DEPTH == 2**ADDR_W.
    assign oor_o = (32'(addr_i) >= 32'(DEPTH));

endmodule

// File: rtl/sram_ctrl.sv
// Single-word request sequencer for the word-cell array: setup, strobe, then a one-cycle response.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WR_CYCLES = DEF_WR_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              op,
    output logic [DEPTH-1:0]  sel_x,
    output logic [DATA_W-1:0] in_bus,
    input  logic [DATA_W-1:0] out_bus
);

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [DEPTH-1:0]    tgt_sel_q, tgt_sel_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                op_q, op_d;
    logic [DEPTH-1:0]    sel_x_q, sel_x_d;
    logic [DATA_W-1:0]   in_bus_q, in_bus_d;

    logic [DEPTH-1:0]    dec_sel;
    logic                dec_oor;

    word_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_word_decoder (
        .addr_i (req_addr),
        .sel_o  (dec_sel),
        .oor_o  (dec_oor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            tgt_sel_q   <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            op_q        <= 1'b0;
            sel_x_q     <= '0;
            in_bus_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            tgt_sel_q   <= tgt_sel_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            op_q        <= op_d;
            sel_x_q     <= sel_x_d;
            in_bus_q    <= in_bus_d;
        end
    end

    // Outputs are computed for the state being entered so every pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        tgt_sel_d   = tgt_sel_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        op_d        = op_q;
        sel_x_d     = sel_x_q;
        in_bus_d    = in_bus_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    state_d   = ST_SETUP;
                    ready_d   = 1'b0;
                    we_d      = req_we;
                    err_d     = dec_oor;
                    tgt_sel_d = dec_sel;
                    in_bus_d  = req_we ? req_wdata : '0;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                sel_x_d = tgt_sel_q;
                op_d    = we_q;
                cnt_d   = we_q ? CNT_W'(WR_CYCLES - 1) : '0;
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    sel_x_d     = '0;
                    op_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    if (!we_q) begin
                        rsp_rdata_d = err_q ? '0 : out_bus;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d   = ST_IDLE;
                rsp_err_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign op        = op_q;
    assign sel_x     = sel_x_q;
    assign in_bus    = in_bus_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (8 words/1-cycle strobe, 6 words/3-cycle strobe) against a word-level model.
module tb_sram_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DA = 8;
    localparam int WA = 1;
    localparam int DB = 6;
    localparam int WB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    int            cur;

    logic          valid_a, ready_a, rv_a, err_a, op_a;
    logic [DW-1:0] rd_a, inb_a, ob_a;
    logic [DA-1:0] sel_a;
    logic          valid_b, ready_b, rv_b, err_b, op_b;
    logic [DW-1:0] rd_b, inb_b, ob_b;
    logic [DB-1:0] sel_b;

    assign valid_a = req_valid && (cur == 0);
    assign valid_b = req_valid && (cur == 1);

    sram_ctrl #(.ADDR_W(AW), .DEPTH(DA), .DATA_W(DW), .WR_CYCLES(WA)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a),
        .op(op_a), .sel_x(sel_a), .in_bus(inb_a), .out_bus(ob_a)
    );

    sram_ctrl #(.ADDR_W(AW), .DEPTH(DB), .DATA_W(DW), .WR_CYCLES(WB)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b),
        .op(op_b), .sel_x(sel_b), .in_bus(inb_b), .out_bus(ob_b)
    );

    // Word-cell array stand-ins driven purely by the controller pins.
    logic [DW-1:0] cell_a [DA] = '{default: '0};
    logic [DW-1:0] cell_b [DB] = '{default: '0};

    always @(posedge clk) begin
        for (int i = 0; i < DA; i++) if (op_a && sel_a[i]) cell_a[i] <= inb_a;
        for (int i = 0; i < DB; i++) if (op_b && sel_b[i]) cell_b[i] <= inb_b;
    end

    always_comb begin
        ob_a = '0;
        ob_b = '0;
        for (int i = 0; i < DA; i++) if (sel_a[i]) ob_a = ob_a | cell_a[i];
        for (int i = 0; i < DB; i++) if (sel_b[i]) ob_b = ob_b | cell_b[i];
    end

    logic          c_ready, c_rv, c_err, c_op;
    logic [DW-1:0] c_rd, c_inb, c_sel;

    always_comb begin
        if (cur == 0) begin
            c_ready = ready_a; c_rv = rv_a; c_err = err_a; c_op = op_a;
            c_rd = rd_a; c_inb = inb_a; c_sel = sel_a;
        end else begin
            c_ready = ready_b; c_rv = rv_b; c_err = err_b; c_op = op_b;
            c_rd = rd_b; c_inb = inb_b; c_sel = {2'b00, sel_b};
        end
    end

    // Reference model: word contents and last read value per instance.
    logic [DW-1:0] ref_mem [2][8];
    logic [DW-1:0] last_rd [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic txn(input int inst, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int            depth;
        int            n;
        bit            oor;
        logic [DW-1:0] exp_sel;
        logic [DW-1:0] exp_inb;
        logic [DW-1:0] exp_rd;
        depth   = (inst == 1) ? DB : DA;
        n       = we ? ((inst == 1) ? WB : WA) : 1;
        oor     = int'(addr) >= depth;
        exp_sel = oor ? '0 : (DW'(1) << addr);
        exp_inb = we ? wd : '0;
        cur = inst;
        #1;
        for (int k = 0; k < 8 && c_ready !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        chk("accept_ready", c_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        scramble();
        chk("setup_op", c_op, 0);
        chk("setup_sel", c_sel, 0);
        chk("setup_inbus", c_inb, exp_inb);
        chk("setup_ready", c_ready, 0);
        chk("setup_rsp", c_rv, 0);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            scramble();
            chk("strobe_op", c_op, we);
            chk("strobe_sel", c_sel, exp_sel);
            chk("strobe_inbus", c_inb, exp_inb);
            chk("strobe_rsp", c_rv, 0);
        end
        if (!we) last_rd[inst] = oor ? '0 : ref_mem[inst][addr];
        else if (!oor) ref_mem[inst][addr] = wd;
        exp_rd = last_rd[inst];
        @(posedge clk); #1;
        scramble();
        chk("resp_valid", c_rv, 1);
        chk("resp_err", c_err, oor);
        chk("resp_rdata", c_rd, exp_rd);
        chk("resp_op", c_op, 0);
        chk("resp_sel", c_sel, 0);
        chk("resp_inbus", c_inb, exp_inb);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("after_rsp_valid", c_rv, 0);
        chk("after_ready", c_ready, 1);
        chk("after_inbus", c_inb, exp_inb);
        chk("after_rdata", c_rd, exp_rd);
        $display("txn inst=%0d we=%0d addr=%0d wdata=0x%0h rdata=0x%0h err=%0d", inst, we, addr, wd, c_rd, c_err);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++) ref_mem[i][j] = '0;
            last_rd[i] = '0;
        end
        cur = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", ready_a, 0);
        chk("rst_ready_b", ready_b, 0);
        chk("rst_op_sel_a", {op_a, sel_a}, 0);
        chk("rst_outs_b", {rv_b, err_b, op_b, sel_b, inb_b, rd_b}, 0);
        chk("rst_outs_a", {rv_a, err_a, inb_a, rd_a}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_ready", {ready_a, ready_b}, 2'b11);
            chk("idle_op_sel_a", {op_a, sel_a, inb_a, rv_a}, 0);
            chk("idle_op_sel_b", {op_b, sel_b, inb_b, rv_b}, 0);
            @(posedge clk); #1;
        end

        txn(0, 1'b1, 3'd3, 8'h55);
        txn(0, 1'b0, 3'd3, 8'h00);
        txn(1, 1'b1, 3'd0, 8'hCC);
        txn(1, 1'b1, 3'd3, 8'h55);
        txn(1, 1'b0, 3'd0, 8'h00);
        txn(1, 1'b0, 3'd3, 8'h00);
        txn(1, 1'b0, 3'd7, 8'h00);
        txn(1, 1'b1, 3'd6, 8'h99);
        txn(1, 1'b0, 3'd0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            txn(i % 2, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
        end

        // Reset during the strobe of a write on the 3-cycle instance.
        cur = 1;
        #1;
        chk("midrst_ready", ready_b, 1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 8'hA7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_strobe_op", op_b, 1);
        chk("midrst_strobe_sel", sel_b, 6'h04);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_op", op_b, 0);
        chk("midrst_sel", sel_b, 0);
        chk("midrst_rsp", rv_b, 0);
        chk("midrst_ready_low", ready_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready_back", ready_b, 1);
        chk("midrst_no_rsp", {rv_b, op_b, sel_b}, 0);
        ref_mem[1][2] = 8'hA7;
        last_rd[0] = '0;
        last_rd[1] = '0;
        txn(1, 1'b0, 3'd2, 8'h00);

        // Reset and request together: the request must be dropped.
        cur = 0;
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'h11;
        rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstreq_ready", ready_a, 1);
        @(posedge clk); #1;
        chk("rstreq_idle", {ready_a, op_a, sel_a, inb_a}, {1'b1, 17'h0});
        last_rd[0] = '0;
        last_rd[1] = '0;
        txn(0, 1'b0, 3'd1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
